// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU select codes, default datapath width and
// the output-stage state encoding.
package alu_pkg;

  localparam int unsigned AluWidth = 32;

  // 3-bit ALU select codes, carried through the issue stage without decoding.
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluOr  = 3'b010;
  localparam logic [2:0] AluXor = 3'b011;
  localparam logic [2:0] AluSlt = 3'b100;
  localparam logic [2:0] AluSll = 3'b101;
  localparam logic [2:0] AluSrl = 3'b110;
  localparam logic [2:0] AluSra = 3'b111;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } issue_state_e;

endpackage

// File: rtl/alu_scoreboard.sv
// Per-register pending bits and source-operand hazard detection for the issue stage.
// With ALU_ISSUE_BYPASS_EN defined, a source written back this cycle is not a hazard.
module alu_scoreboard #(
  parameter int unsigned NREG = 8,
  localparam int unsigned RW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en,
  input  logic [RW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [RW-1:0] clr_idx,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic          rs2_used,
  output logic          hazard
);

  logic [NREG-1:0] pending_q, pending_d;
  logic            rs1_busy, rs2_busy;

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    pending_d = pending_q;
    if (clr_en && clr_idx != '0) begin
      pending_d[clr_idx] = 1'b0;
    end
    if (set_en && set_idx != '0) begin
      pending_d[set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rs1_busy = pending_q[rs1];
    rs2_busy = rs2_used && pending_q[rs2];
`ifdef ALU_ISSUE_BYPASS_EN
    if (clr_en && clr_idx == rs1) begin
      rs1_busy = 1'b0;
    end
    if (clr_en && clr_idx == rs2) begin
      rs2_busy = 1'b0;
    end
`endif
    hazard = rs1_busy || rs2_busy;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: register file, scoreboard-gated accept and a one-entry output register
// feeding the ALU. Define ALU_ISSUE_BYPASS_EN to forward same-cycle writeback data.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth,
  parameter int unsigned NREG  = 8,
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [RW-1:0]    in_rd,
  input  logic [RW-1:0]    in_rs1,
  input  logic [RW-1:0]    in_rs2,
  input  logic             in_use_imm,
  input  logic [WIDTH-1:0] in_imm,

  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_sel,
  output logic [RW-1:0]    out_rd,

  input  logic             wb_en,
  input  logic [RW-1:0]    wb_rd,
  input  logic [WIDTH-1:0] wb_data
);

  issue_state_e     state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] opr_a, opr_b;
  logic [WIDTH-1:0] out_a_q, out_b_q;
  logic [2:0]       out_sel_q;
  logic [RW-1:0]    out_rd_q;
  logic             hazard;
  logic             accept;

  alu_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (accept),
    .set_idx  (in_rd),
    .clr_en   (wb_en),
    .clr_idx  (wb_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .rs2_used (!in_use_imm),
    .hazard   (hazard)
  );

  // r0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en && wb_rd != '0) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    opr_a = regs_q[in_rs1];
    opr_b = in_use_imm ? in_imm : regs_q[in_rs2];
`ifdef ALU_ISSUE_BYPASS_EN
    if (wb_en && wb_rd == in_rs1) begin
      opr_a = wb_data;
    end
    if (!in_use_imm && wb_en && wb_rd == in_rs2) begin
      opr_b = wb_data;
    end
`endif
    // Index zero overrides any forwarded value: writes to r0 never become visible.
    if (in_rs1 == '0) begin
      opr_a = '0;
    end
    if (!in_use_imm && in_rs2 == '0) begin
      opr_b = '0;
    end
  end

  assign in_ready = ((state_q == StEmpty) || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StFull;
        end
      end
      StFull: begin
        if (out_ready && !accept) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_sel_q <= '0;
      out_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        out_a_q   <= opr_a;
        out_b_q   <= opr_b;
        out_sel_q <= in_op;
        out_rd_q  <= in_rd;
      end
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_sel   = out_sel_q;
  assign out_rd    = out_rd_q;

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have parameter NREG, default 8, giving the number of architectural registers (power of two, >=2); RW = log2(NREG).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning an instruction is offered.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the instruction is accepted this cycle.
REQ-007 The block SHALL have ports in_op (input, 3, ALU select code 000-111), in_rd, in_rs1 and in_rs2 (input, RW, register indices), in_use_imm (input, 1, use the immediate as operand b) and in_imm (input, WIDTH, immediate).
REQ-008 The block SHALL have port out_valid, output, 1, meaning the operand bundle is valid for the ALU.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the ALU consumer accepts the bundle.
REQ-010 The block SHALL have ports out_a and out_b (output, WIDTH, ALU operands), out_sel (output, 3, ALU select) and out_rd (output, RW, destination tag).
REQ-011 The block SHALL have ports wb_en (input, 1), wb_rd (input, RW) and wb_data (input, WIDTH), carrying the ALU result writeback.

Function
REQ-012 The block SHALL hold an NREG x WIDTH register file; r0 reads as zero, and writes to r0 are ignored.
REQ-013 On wb_en with wb_rd!=0, the block SHALL write wb_data to reg[wb_rd] and clear pending[wb_rd].
REQ-014 The block SHALL keep a pending bit per register; an accepted instruction with in_rd!=0 sets pending[in_rd].
REQ-015 When a pending set and a pending clear hit the same index in the same cycle, the set SHALL win.
REQ-016 A hazard SHALL exist when pending[rs1], or pending[rs2] with in_use_imm=0, is set and is not resolved by the bypass (REQ-025).
REQ-017 The output stage SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-018 in_ready SHALL equal (state==EMPTY or out_ready) and no hazard; it is combinational.
REQ-019 Accept is in_valid and in_ready; on accept the output registers SHALL load the bundle in the same edge, so latency is 1 cycle with no bubble under continuous streaming.
REQ-020 State transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready without accept; FULL->FULL on out_ready with accept, or on !out_ready (outputs held stable).
REQ-021 Operand a SHALL be reg[rs1]; operand b SHALL be in_imm if in_use_imm=1, else reg[rs2]; rs==0 yields zero.
REQ-022 A same-cycle write and read of the same register SHALL return wb_data (write-through) when ALU_ISSUE_BYPASS_EN is defined.
REQ-023 out_sel SHALL be in_op passed unchanged; the block does not decode opcodes.

Reset
REQ-024 rst_n low SHALL asynchronously force state=EMPTY, out_valid=0, out_a/out_b=0, out_sel=0, out_rd=0, all pending=0 and all registers=0; this holds even while a bundle is in flight, and that bundle is dropped.

Configuration
REQ-025 With ALU_ISSUE_BYPASS_EN defined, a pending source matching wb_rd with wb_en=1 in the same cycle SHALL be no hazard, and its operand SHALL be wb_data.
REQ-026 Without ALU_ISSUE_BYPASS_EN, such a source SHALL stall for one cycle and be read from the register file on the next cycle; there is no write-through, so the hazard covers it.

Structure
REQ-027 A shared package alu_pkg SHALL hold the 3-bit ALU select constants (ADD, SUB, OR, XOR, SLT, SLL, SRL, SRA) and the default WIDTH.
REQ-028 The scoreboard (pending bits, set/clear priority, hazard compare) SHALL be a sub-module, alu_scoreboard.

Verification
REQ-029 The bench SHALL cover: after reset, issue op=000, rd=1, rs1=0, use_imm=1, imm=5 -> next cycle out_valid=1, out_a=0, out_b=5, out_sel=000, out_rd=1, and pending[1]=1.
REQ-030 The bench SHALL cover: with pending[1]=1, offer rs1=1 with no wb -> in_ready=0 held; then wb_en, wb_rd=1, wb_data=0x10 -> with BYPASS_EN accepted that cycle with out_a=0x10, without BYPASS_EN accepted one cycle later with out_a=0x10.
REQ-031 The bench SHALL cover: out_ready=0 for 3 cycles with in_valid=1 and no hazard -> out_* stable, in_ready=0; out_ready=1 -> the next bundle loads in the same cycle with no bubble.
REQ-032 The bench SHALL cover: wb_en with wb_rd=0, wb_data=0xFFFFFFFF, then read rs1=0 -> out_a=0.
REQ-033 The bench SHALL cover: an accept of rd=2 in the same cycle as wb_en with wb_rd=2 -> pending[2]=1 afterwards.
REQ-034 The bench SHALL cover: rst_n low while FULL -> out_valid=0 immediately (asynchronous), and all pending bits clear.
